vz_alu_exec: RTL and testbench

- Parametrised, handshaked execute-stage ALU for the vz CPU family.
- Replaces the fixed 16-bit single-cycle ALU path with a WIDTH-generic unit.
- Single-cycle ops: add/sub/logic. Iterative ops: multiply (shift-add) and divide (restoring).
- Owns the status register: sign-mode, carry, zero, overflow and divide-by-zero flags.
- Sits between decode (operands already read from the register file) and writeback.

---
 rtl/vz_alu_exec.sv | 143 ++++++++++++++
 tb/tb_vz_alu_exec.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vz_alu_exec.sv
// vz_alu_exec: handshaked execute-stage ALU with iterative shift-add multiply,
// restoring divide and the S/C/Z/V/D status register.
module vz_alu_exec #(
  parameter int WIDTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_set_mode,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_res,
  output logic [WIDTH-1:0]  out_aux,
  output logic              out_aux_we,
  output logic              out_res_we,
  output logic [STAT_W-1:0] status
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100, OP_OR = 3'b101, OP_XOR = 3'b110;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd, hi, lo;
  logic             s, c, z, v, d;
  logic             fire, set_mode, div0, mul_start, div_start, last;
  logic             add_v, sub_v;
  logic [WIDTH:0]   add_r, sub_r, mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] sc_res;
  logic             ld, ld_res_we, ld_aux_we, ld_s, ld_c, ld_z, ld_v, ld_d;
  logic [WIDTH-1:0] ld_res, ld_aux;

  assign in_ready  = state == IDLE && (!out_valid || out_ready);
  assign fire      = in_valid && in_ready;
  assign set_mode  = in_op == 3'b111 && in_set_mode;
  assign div0      = in_op == OP_DIV && in_b == '0;
  assign mul_start = fire && in_op == OP_MUL;
  assign div_start = fire && in_op == OP_DIV && !div0;
  assign last      = state != IDLE && cnt == CW'(WIDTH - 1);

  assign add_r = {1'b0, in_a} + {1'b0, in_b};
  assign sub_r = {1'b0, in_a} - {1'b0, in_b};
  assign add_v = in_a[WIDTH-1] == in_b[WIDTH-1] && add_r[WIDTH-1] != in_a[WIDTH-1];
  assign sub_v = in_a[WIDTH-1] != in_b[WIDTH-1] && sub_r[WIDTH-1] != in_a[WIDTH-1];
  assign sc_res = in_op == OP_ADD ? add_r[WIDTH-1:0] :
                  in_op == OP_SUB ? sub_r[WIDTH-1:0] :
                  in_op == OP_AND ? in_a & in_b :
                  in_op == OP_OR  ? in_a | in_b :
                  in_op == OP_XOR ? in_a ^ in_b : ~in_a;

  // hi:lo is the running product (mul) or remainder:dividend/quotient (div)
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};

  assign status = STAT_W'({s, c, z, v, d}) << (STAT_W - 5);

  always_comb begin
    ld        = last || (fire && !mul_start && !div_start);
    ld_res    = sc_res;
    ld_aux    = '0;
    ld_res_we = 1'b1;
    ld_aux_we = 1'b0;
    ld_s      = s;
    ld_c      = 1'b0;
    ld_v      = 1'b0;
    ld_d      = 1'b0;
    if (state == MUL) begin
      ld_res    = {mul_sum[0], lo[WIDTH-1:1]};
      ld_aux    = mul_sum[WIDTH:1];
      ld_aux_we = 1'b1;
      ld_c      = !s && ld_aux != '0;
      ld_v      = s && ld_aux != '0;
    end else if (state == DIV) begin
      ld_res    = {lo[WIDTH-2:0], !div_diff[WIDTH]};
      ld_aux    = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      ld_aux_we = 1'b1;
    end else if (div0) begin
      ld_res    = '1;
      ld_aux    = in_a;
      ld_aux_we = 1'b1;
      ld_d      = 1'b1;
    end else if (set_mode) begin
      ld_res    = '0;
      ld_res_we = 1'b0;
      ld_s      = in_a[0];
      ld_c      = c;
      ld_v      = v;
      ld_d      = d;
    end else if (in_op == OP_ADD) begin
      ld_c = !s && add_r[WIDTH];
      ld_v = s && add_v;
    end else if (in_op == OP_SUB) begin
      ld_c = !s && sub_r[WIDTH];
      ld_v = s && sub_v;
    end
    ld_z = ld_res_we ? ld_res == '0 : z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      opnd       <= '0;
      hi         <= '0;
      lo         <= '0;
      out_valid  <= 1'b0;
      out_res    <= '0;
      out_aux    <= '0;
      out_aux_we <= 1'b0;
      out_res_we <= 1'b0;
      {s, c, z, v, d} <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (ld) begin
        out_valid  <= 1'b1;
        out_res    <= ld_res;
        out_aux    <= ld_aux;
        out_aux_we <= ld_aux_we;
        out_res_we <= ld_res_we;
        {s, c, z, v, d} <= {ld_s, ld_c, ld_z, ld_v, ld_d};
      end
      if (mul_start || div_start) begin
        state <= mul_start ? MUL : DIV;
        opnd  <= mul_start ? in_a : in_b;
        lo    <= mul_start ? in_b : in_a;
        hi    <= '0;
        cnt   <= '0;
      end else if (state != IDLE) begin
        hi  <= ld_aux;
        lo  <= ld_res;
        cnt <= cnt + 1'b1;
        if (last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_vz_alu_exec.sv
// tb_vz_alu_exec: vector table plus scoreboard for vz_alu_exec (WIDTH 16 and 8).
module tb_vz_alu_exec;
  typedef struct {
    logic [15:0] res, aux;
    logic        aux_we, res_we;
    logic [15:0] st;
  } exp_t;
  typedef struct {
    logic [2:0]  op;
    logic        sm;
    logic [15:0] a, b;
    exp_t        e;
    int          lat;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, in_set_mode = 1'b0, out_valid, out_ready = 1'b1;
  logic        out_aux_we, out_res_we;
  logic [2:0]  in_op = '0;
  logic [15:0] in_a = '0, in_b = '0, out_res, out_aux, status;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_aux_we8, out_res_we8;
  logic [2:0]  in_op8 = '0;
  logic [7:0]  in_a8 = '0, in_b8 = '0, out_res8, out_aux8;
  logic [4:0]  status8;

  vz_alu_exec #(.WIDTH(16), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_set_mode(in_set_mode), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_aux(out_aux), .out_aux_we(out_aux_we),
    .out_res_we(out_res_we), .status(status));

  vz_alu_exec #(.WIDTH(8), .STAT_W(5)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
    .in_set_mode(1'b0), .in_a(in_a8), .in_b(in_b8), .out_valid(out_valid8),
    .out_ready(1'b1), .out_res(out_res8), .out_aux(out_aux8), .out_aux_we(out_aux_we8),
    .out_res_we(out_res_we8), .status(status8));

  exp_t sb[$];
  exp_t me;
  int   nvec = 0, nerr = 0;

  function automatic vec_t vt(logic [2:0] op, logic sm, logic [15:0] a, logic [15:0] b,
                              logic [15:0] res, logic [15:0] aux, logic aw, logic rw,
                              logic [15:0] st, int lat);
    vt.op = op; vt.sm = sm; vt.a = a; vt.b = b;
    vt.e.res = res; vt.e.aux = aux; vt.e.aux_we = aw; vt.e.res_we = rw; vt.e.st = st;
    vt.lat = lat;
  endfunction

  // scoreboard: every retired result must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_result res=%h aux=%h status=%h", out_res, out_aux, status);
      end else begin
        me = sb.pop_front();
        if (out_res_we !== me.res_we || out_aux_we !== me.aux_we || status !== me.st ||
            (me.res_we && out_res !== me.res) || (me.aux_we && out_aux !== me.aux)) begin
          nerr++;
          $display("FAIL result got res=%h aux=%h rwe=%b awe=%b st=%h want res=%h aux=%h rwe=%b awe=%b st=%h",
                   out_res, out_aux, out_res_we, out_aux_we, status,
                   me.res, me.aux, me.res_we, me.aux_we, me.st);
        end
      end
    end
  end

  task automatic send(input vec_t t, output int lat, output bit busy_ok);
    int g = 0;
    in_op = t.op; in_set_mode = t.sm; in_a = t.a; in_b = t.b; in_valid = 1'b1;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (!in_ready) begin nvec++; nerr++; $display("FAIL accept_timeout op=%b", t.op); end
    sb.push_back(t.e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_set_mode = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    int g = 0;
    in_op8 = op; in_a8 = a; in_b8 = b; in_valid8 = 1'b1;
    while (!in_ready8 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  vec_t vec[22];
  int   lat;
  bit   bz, stale;

  initial begin
    vec[0]  = vt(3'b000, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 1, 16'h6000, 1);
    vec[1]  = vt(3'b111, 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'hE000, 1);
    vec[2]  = vt(3'b000, 0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 1, 16'h9000, 1);
    vec[3]  = vt(3'b111, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h1000, 1);
    vec[4]  = vt(3'b010, 0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1, 1, 16'h4000, 17);
    vec[5]  = vt(3'b011, 0, 16'd100,  16'd7,    16'd14,   16'd2,    1, 1, 16'h0000, 17);
    vec[6]  = vt(3'b011, 0, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1, 1, 16'h0800, 1);
    vec[7]  = vt(3'b100, 0, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 0, 1, 16'h0000, 1);
    vec[8]  = vt(3'b101, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h2000, 1);
    vec[9]  = vt(3'b110, 0, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 0, 1, 16'h0000, 1);
    vec[10] = vt(3'b111, 0, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 0, 1, 16'h0000, 1);
    vec[11] = vt(3'b001, 0, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 0, 1, 16'h4000, 1);
    vec[12] = vt(3'b001, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 0, 1, 16'h2000, 1);
    vec[13] = vt(3'b000, 1, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0, 1, 16'h0000, 1);
    vec[14] = vt(3'b111, 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h8000, 1);
    vec[15] = vt(3'b001, 0, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 1, 16'h9000, 1);
    vec[16] = vt(3'b010, 0, 16'h0002, 16'h8000, 16'h0000, 16'h0001, 1, 1, 16'hB000, 17);
    vec[17] = vt(3'b111, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h3000, 1);
    vec[18] = vt(3'b010, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 1, 16'h4000, 17);
    vec[19] = vt(3'b011, 0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1, 1, 16'h0000, 17);
    vec[20] = vt(3'b011, 0, 16'h1234, 16'h1234, 16'h0001, 16'h0000, 1, 1, 16'h0000, 17);
    vec[21] = vt(3'b011, 0, 16'h0007, 16'h0009, 16'h0000, 16'h0007, 1, 1, 16'h2000, 17);

    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_res !== 16'h0 || out_aux !== 16'h0 || out_aux_we !== 1'b0 ||
        out_res_we !== 1'b0 || status !== 16'h0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_state valid=%b res=%h aux=%h st=%h rdy=%b want 0/0/0/0/1",
               out_valid, out_res, out_aux, status, in_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      send(vec[i], lat, bz);
      nvec++;
      if (lat != vec[i].lat || !bz) begin
        nerr++;
        $display("FAIL latency vec=%0d got=%0d busy_ok=%b want=%0d", i, lat, bz, vec[i].lat);
      end
    end

    // back-to-back single-cycle ops, one per cycle
    for (int i = 1; i <= 3; i++) begin
      in_op = 3'b000; in_a = 16'(i); in_b = 16'(i); in_valid = 1'b1;
      nvec++;
      if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready op=%0d got=%b want=1", i, in_ready); end
      sb.push_back(vt(3'b000, 0, 0, 0, 16'(2 * i), 16'h0, 0, 1, 16'h0000, 1).e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // backpressure: held xor result blocks a pending add
    out_ready = 1'b0;
    send(vt(3'b110, 0, 16'h0F0F, 16'h00FF, 16'h0FF0, 16'h0, 0, 1, 16'h0000, 1), lat, bz);
    nvec++;
    if (lat != 1) begin nerr++; $display("FAIL xor_latency got=%0d want=1", lat); end
    in_op = 3'b000; in_a = 16'hFFFF; in_b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      nvec++;
      if (out_valid !== 1'b1 || out_res !== 16'h0FF0 || status !== 16'h0000 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL hold cyc=%0d valid=%b res=%h st=%h rdy=%b want 1/0ff0/0000/0",
                 i, out_valid, out_res, status, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL release_ready got=%b want=1", in_ready); end
    sb.push_back(vt(3'b000, 0, 0, 0, 16'h0000, 16'h0, 0, 1, 16'h6000, 1).e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // make status nonzero, then reset in the middle of a divide
    send(vt(3'b111, 1, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 0, 16'hE000, 1), lat, bz);
    repeat (2) @(posedge clk);
    #1;
    in_op = 3'b011; in_a = 16'd100; in_b = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || status !== 16'h0 || out_res !== 16'h0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid_div valid=%b st=%h res=%h rdy=%b want 0/0000/0000/1",
               out_valid, status, out_res, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    nvec++;
    if (stale || in_ready !== 1'b1 || status !== 16'h0) begin
      nerr++;
      $display("FAIL after_reset stale=%b rdy=%b st=%h want 0/1/0000", stale, in_ready, status);
    end

    // WIDTH=8, STAT_W=5 instance
    send8(3'b001, 8'h00, 8'h01, lat);
    nvec++;
    if (lat != 1 || out_res8 !== 8'hFF || status8 !== 5'b01000 || out_aux_we8 !== 1'b0) begin
      nerr++;
      $display("FAIL w8_sub lat=%0d res=%h st=%b want 1/ff/01000", lat, out_res8, status8);
    end
    send8(3'b010, 8'hFF, 8'hFF, lat);
    nvec++;
    if (lat != 9 || out_res8 !== 8'h01 || out_aux8 !== 8'hFE || status8 !== 5'b01000 || out_aux_we8 !== 1'b1) begin
      nerr++;
      $display("FAIL w8_mul lat=%0d res=%h aux=%h st=%b want 9/01/fe/01000", lat, out_res8, out_aux8, status8);
    end
    send8(3'b011, 8'd200, 8'd7, lat);
    nvec++;
    if (lat != 9 || out_res8 !== 8'd28 || out_aux8 !== 8'd4 || status8 !== 5'b00000) begin
      nerr++;
      $display("FAIL w8_div lat=%0d res=%0d aux=%0d st=%b want 9/28/4/00000", lat, out_res8, out_aux8, status8);
    end

    repeat (3) @(posedge clk);
    nvec++;
    if (sb.size() != 0) begin nerr++; $display("FAIL pending_results got=%0d want=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
